text_term_ctrl: RTL
===================

// Module: text_term_ctrl
// PURPOSE
//  Terminal-style write controller for the 70x30 text-mode character buffer that feeds the VGA character renderer.
//  Accepts an ASCII byte stream (keyboard / UART), tracks the cursor and handles CR, LF, BS and FF.
//  Scrolls by rotating a ring-buffer row base, and sequences every write into the char-RAM write port.
//  The display read side maps logical row r to physical row (r+row_base) mod ROWS.
// PARAMETERS
//  COLS       70    characters per row
//  ROWS       30    character rows
//  ADDR_W     12    char-RAM address width (must satisfy ROWS*COLS <= 2**ADDR_W)
//  FILL_CHAR  8'h20 byte written by clear operations
// PORTS
//  pclk       in   1       pixel clock (25 MHz); all state changes on rising edge
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       in_char is valid
//  in_ready   out  1       controller can accept a byte this cycle
//  in_char    in   8       ASCII byte
//  wr_en      out  1       char-RAM write strobe (registered)
//  wr_addr    out  ADDR_W  physical char-RAM address = phys_row*COLS + col
//  wr_data    out  8       byte to write
//  cursor_x   out  8       logical cursor column, 0..COLS-1
//  cursor_y   out  8       logical cursor row, 0..ROWS-1
//  row_base   out  5       physical row shown as logical row 0
//  busy       out  1       high in CLEAR_ROW / CLEAR_ALL
// BEHAVIOUR
//  Reset (async): state=CLEAR_ALL, clr_cnt=0, cursor=(0,0), row_base=0, wr_en=0, wr_addr=0, wr_data=0.
//   in_ready=0 and busy=1 while reset is asserted.
//  Reset asserted in any state, including mid-clear, aborts the operation and restarts CLEAR_ALL from address 0.
//  States:
//   CLEAR_ALL: one write per cycle, addr 0..ROWS*COLS-1, data FILL_CHAR; then IDLE.
//    Exactly ROWS*COLS write cycles; the first write occurs on the first edge after reset release.
//   IDLE: in_ready=1. A byte is accepted on a rising edge with in_valid&in_ready.
//    All outputs are registered on the accept edge, so wr_en is visible the following cycle (latency 1).
//    Back-to-back acceptance at 1 byte/cycle is allowed while no scroll or clear is triggered.
//   CLEAR_ROW: COLS cycles, addr = old_row_base*COLS + i for i=0..COLS-1, data FILL_CHAR; then IDLE.
//   In both clear states: in_ready=0, busy=1.
//  Byte handling (cursor x,y; phys_row = y+row_base, minus ROWS if >= ROWS):
//   0x20..0x7E: write byte at (x,y), then x++.
//    If x reaches COLS: x=0 and NEWLINE.
//   0x0D CR: x=0, no write.
//   0x0A LF: x=0, NEWLINE, no write.
//   0x08 BS:
//    x>0: x--, write FILL_CHAR at the new (x,y).
//    x==0,y>0: y--, x=COLS-1, write FILL_CHAR at the new position.
//    (0,0): no-op, no write.
//   0x0C FF: cursor=(0,0), row_base=0, enter CLEAR_ALL.
//   Any other byte: accepted and ignored; no write, no cursor change.
//  NEWLINE:
//   If y<ROWS-1: y++.
//   Else (scroll): y stays ROWS-1, row_base=(row_base+1) mod ROWS, enter CLEAR_ROW on the old row_base (the new bottom row).
//  Printable at (COLS-1,ROWS-1): the char write and the scroll occur on the same accept edge.
//   The char write is presented in the first cycle; CLEAR_ROW writes follow in the next COLS cycles.
//   in_ready is low for exactly COLS cycles after that first cycle.
//  wr_en=0 in every IDLE cycle with no accepted write-producing byte.
//   wr_addr and wr_data hold their last values when wr_en=0.
//  Arithmetic: row_base wraps ROWS-1 -> 0; addr = phys_row*COLS + col, computed in ADDR_W bits, never exceeds ROWS*COLS-1.
// TESTING
//  T1 Release reset -> 2100 consecutive wr_en cycles, addr 0..2099, data 0x20, in_ready=0; then in_ready=1, cursor (0,0).
//  T2 Send 0x41 at (0,0) -> next cycle wr_en=1, addr 0, data 0x41; cursor (1,0).
//  T3 70 back-to-back 0x42 from (0,0) -> addrs 0..69 on consecutive cycles, no in_ready drop; cursor (0,1).
//  T4 Cursor (5,29), row_base 0, send 0x0A -> row_base 1, 70 writes addr 0..69 of 0x20, in_ready low 70 cycles, cursor (0,29); then 0x43 writes addr 0.
//  T5 BS at (0,3), row_base 0 -> cursor (69,2), write 0x20 at addr 209; BS at (0,0) -> no write, cursor unchanged.
//  T6 0x0C with row_base 7 -> full 2100-cycle clear, row_base 0, cursor (0,0); reset at cycle 30 of CLEAR_ROW -> restart CLEAR_ALL from addr 0.

Source files
------------

// File: rtl/text_term_ctrl.sv
// ============================================================================
//  Module      : text_term_ctrl
//  Description : Terminal-style write controller for a ring-buffered text-mode
//                character RAM (cursor, CR/LF/BS/FF handling, scroll, clears).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_term_ctrl #(
    parameter int         COLS      = 70,
    parameter int         ROWS      = 30,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        cursor_x,
    output logic [7:0]        cursor_y,
    output logic [4:0]        row_base,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_CLEAR_ALL = 2'd0,
        S_IDLE      = 2'd1,
        S_CLEAR_ROW = 2'd2
    } state_t;

    localparam logic [7:0]        c_rows     = 8'(ROWS);
    localparam logic [7:0]        c_last_col = 8'(COLS - 1);
    localparam logic [7:0]        c_last_row = 8'(ROWS - 1);
    localparam logic [4:0]        c_last_base = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] c_cols_a   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_cols_m1a = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_total_m1 = ADDR_W'(ROWS * COLS - 1);

    state_t              r_state,    w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt,  w_clr_cnt_nxt;
    logic [7:0]          r_cur_x,    w_x_nxt;
    logic [7:0]          r_cur_y,    w_y_nxt;
    logic [4:0]          r_row_base, w_rb_nxt;
    logic [4:0]          r_clr_base, w_clr_base_nxt;
    logic                r_wr_en,    w_wr_en_nxt;
    logic [ADDR_W-1:0]   r_wr_addr,  w_wr_addr_nxt;
    logic [7:0]          r_wr_data,  w_wr_data_nxt;
    logic                w_newline;

    // Logical (x,y) to physical RAM address through the ring-buffer base.
    function automatic logic [ADDR_W-1:0] f_addr(input logic [7:0] y,
                                                  input logic [4:0] base,
                                                  input logic [7:0] x);
        logic [7:0] phys;
        phys = y + {3'b000, base};
        if (phys >= c_rows)
            phys = phys - c_rows;
        return ADDR_W'(phys) * c_cols_a + ADDR_W'(x);
    endfunction

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_CLEAR_ALL;
            r_clr_cnt  <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_row_base <= '0;
            r_clr_base <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_cur_x    <= w_x_nxt;
            r_cur_y    <= w_y_nxt;
            r_row_base <= w_rb_nxt;
            r_clr_base <= w_clr_base_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_x_nxt        = r_cur_x;
        w_y_nxt        = r_cur_y;
        w_rb_nxt       = r_row_base;
        w_clr_base_nxt = r_clr_base;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_newline      = 1'b0;

        case (r_state)
            S_CLEAR_ALL: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_clr_cnt;
                w_wr_data_nxt = FILL_CHAR;
                if (r_clr_cnt == c_total_m1) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end

            S_CLEAR_ROW: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = f_addr(8'd0, r_clr_base, 8'(r_clr_cnt));
                w_wr_data_nxt = FILL_CHAR;
                if (r_clr_cnt == c_cols_m1a) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end

            S_IDLE: begin
                if (in_valid) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = f_addr(r_cur_y, r_row_base, r_cur_x);
                        w_wr_data_nxt = in_char;
                        if (r_cur_x == c_last_col) begin
                            w_x_nxt   = '0;
                            w_newline = 1'b1;
                        end else begin
                            w_x_nxt = r_cur_x + 8'd1;
                        end
                    end else begin
                        case (in_char)
                            8'h0D: w_x_nxt = '0;
                            8'h0A: begin
                                w_x_nxt   = '0;
                                w_newline = 1'b1;
                            end
                            8'h08: begin
                                if (r_cur_x != 8'd0) begin
                                    w_x_nxt       = r_cur_x - 8'd1;
                                    w_wr_en_nxt   = 1'b1;
                                    w_wr_addr_nxt = f_addr(r_cur_y, r_row_base, r_cur_x - 8'd1);
                                    w_wr_data_nxt = FILL_CHAR;
                                end else if (r_cur_y != 8'd0) begin
                                    w_x_nxt       = c_last_col;
                                    w_y_nxt       = r_cur_y - 8'd1;
                                    w_wr_en_nxt   = 1'b1;
                                    w_wr_addr_nxt = f_addr(r_cur_y - 8'd1, r_row_base, c_last_col);
                                    w_wr_data_nxt = FILL_CHAR;
                                end
                            end
                            8'h0C: begin
                                w_x_nxt       = '0;
                                w_y_nxt       = '0;
                                w_rb_nxt      = '0;
                                w_clr_cnt_nxt = '0;
                                w_state_nxt   = S_CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // At the bottom row the old base becomes the new, blank bottom row.
                    if (w_newline) begin
                        if (r_cur_y != c_last_row) begin
                            w_y_nxt = r_cur_y + 8'd1;
                        end else begin
                            w_rb_nxt       = (r_row_base == c_last_base) ? 5'd0 : r_row_base + 5'd1;
                            w_clr_base_nxt = r_row_base;
                            w_clr_cnt_nxt  = '0;
                            w_state_nxt    = S_CLEAR_ROW;
                        end
                    end
                end
            end

            default: begin
                w_clr_cnt_nxt = '0;
                w_state_nxt   = S_CLEAR_ALL;
            end
        endcase
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cursor_x = r_cur_x;
    assign cursor_y = r_cur_y;
    assign row_base = r_row_base;

endmodule

`default_nettype wire
